// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the CPU data-port SRAM responder.
// Access size codes, FSM state encodings and the byte-enable / error decode helpers.
// Pure declarations; no logic of its own.
package data_sram_responder_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Lane mask for an access; size 3 is rejected by addr_err so its mask is irrelevant.
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      be = 4'b1111;
      unique case (size)
         SIZE_BYTE: be = 4'b0001 << lo;
         SIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   // Misaligned half/word or the illegal size code.
   function automatic logic addr_err(input logic [1:0] size, input logic [1:0] lo);
      return (size == SIZE_HALF && lo[0]) ||
             (size == SIZE_WORD && lo != 2'b00) ||
             (size == 2'd3);
   endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-memory request/response bundle between the CPU memory stage and the responder.
// master = CPU side (drives the request), slave = memory side (drives the response).
// Signals only; timing is defined by the responder.
interface data_sram_responder_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;
   logic        err;

   modport master (
      output req, wr, size, addr, wdata,
      input  addr_ok, data_ok, rdata, err
   );

   modport slave (
      input  req, wr, size, addr, wdata,
      output addr_ok, data_ok, rdata, err
   );
endinterface

// File: rtl/data_sram_responder_spram.sv
// Single-port 2^ADDR_W x 32 RAM with per-byte write enables and a registered read.
// Read data appears one edge after re_i; a lane written on the same edge returns the new byte.
// No backpressure, no reset: contents and read register power up undefined.
module spram_be #(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic [3:0]        we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o
);
   logic [31:0] mem_q [0:(1<<ADDR_W)-1];
   logic [31:0] rdata_q;

   // Byte-lane writes; the read register is write-first so a same-edge store is visible.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) begin
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
         if (re_i) begin
            rdata_q[8*b +: 8] <= we_i[b] ? wdata_i[8*b +: 8] : mem_q[addr_i][8*b +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_responder.sv
// CPU data-port memory responder: single outstanding load/store, byte-lane writes, full-word reads.
// Latency: data_ok is high in the cycle after edge k+LATENCY-1 when the request is accepted at edge k.
// Backpressure: addr_ok low while a response is pending (WAIT); the CPU holds req until accepted.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic                 clka,
   input  logic                 rst,
   data_sram_responder_if.slave bus
);
   localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
   localparam bit         SINGLE   = (LATENCY == 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] idx_q;
   logic              err_cap_q;
   logic              err_q;
   logic              rvld_q;

   logic              accept;
   logic              dec_err;
   logic [3:0]        dec_be;
   logic              resp_load;
   logic              resp_err;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_we;
   logic [31:0]       ram_rdata;
   logic              unused_addr_hi;

   // Upper address bits are ignored so addresses alias modulo the array size.
   assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

   assign bus.addr_ok = (state_q == ST_IDLE) || (state_q == ST_RESP);
   assign accept      = bus.req && bus.addr_ok;
   assign dec_err     = addr_err(bus.size, bus.addr[1:0]);
   assign dec_be      = byte_en(bus.size, bus.addr[1:0]);

   // Writes only ever happen at acceptance (IDLE/RESP), reads of a waiting request only in WAIT,
   // so the single port never sees both from different requests in one cycle.
   assign ram_addr = (state_q == ST_WAIT) ? idx_q : bus.addr[ADDR_W+1:2];
   assign ram_we   = (accept && bus.wr && !dec_err) ? dec_be : 4'b0000;

   spram_be #(.ADDR_W(ADDR_W)) u_ram (
      .clk_i   (clka),
      .we_i    (ram_we),
      .re_i    (resp_load),
      .addr_i  (ram_addr),
      .wdata_i (bus.wdata),
      .rdata_o (ram_rdata)
   );

   // Next state, latency countdown and the response-entry strobe.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      resp_load = 1'b0;
      resp_err  = (state_q == ST_WAIT) ? err_cap_q : dec_err;
      unique case (state_q)
         ST_IDLE, ST_RESP: begin
            if (accept) begin
               if (SINGLE) begin
                  state_d   = ST_RESP;
                  resp_load = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_LOAD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d   = ST_RESP;
               resp_load = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers; reset drops any pending response.
   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Capture what the delayed response still needs at acceptance.
   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         idx_q     <= '0;
         err_cap_q <= 1'b0;
      end else if (accept) begin
         idx_q     <= bus.addr[ADDR_W+1:2];
         err_cap_q <= dec_err;
      end
   end

   // Response flags update on entry to RESP and hold afterwards.
   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         err_q  <= 1'b0;
         rvld_q <= 1'b0;
      end else if (resp_load) begin
         err_q  <= resp_err;
         rvld_q <= !resp_err;
      end
   end

   assign bus.data_ok = (state_q == ST_RESP);
   assign bus.err     = err_q;
   assign bus.rdata   = rvld_q ? ram_rdata : 32'd0;
endmodule
